// File: rtl/sevenseg_pkg.sv
// Shared constants and BCD helpers for the counter/scanner feeding the seven-segment decoder.
package sevenseg_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int UNITS = 0;
  localparam int TENS  = 1;

  // {tens, units} + 1, wrapping 99 -> 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u >= 4'd9) begin
      u = 4'd0;
      t = (t >= 4'd9) ? 4'd0 : t + 4'd1;
    end else begin
      u = u + 4'd1;
    end
    return {t, u};
  endfunction

  // {tens, units} - 1, wrapping 00 -> 99
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = v[3:0];
    t = v[7:4];
    if (u == 4'd0) begin
      u = 4'd9;
      t = (t == 4'd0) ? 4'd9 : t - 4'd1;
    end else begin
      u = u - 4'd1;
    end
    return {t, u};
  endfunction

  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    logic [3:0] u;
    logic [3:0] t;
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    return {t, u};
  endfunction

endpackage

// File: rtl/strobe_div.sv
// Free-running modulo-DIV counter; stb_o flags the enabled terminal-count cycle.
module strobe_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic stb_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Combinational so the owner can register its own reaction on this same edge
  assign stb_o = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with prescaler and a two-slot digit scanner.
module bcd_scan_counter
  import sevenseg_pkg::*;
#(
  parameter int TICK_DIV = 12000000,
  parameter int SCAN_DIV = 12000,
  parameter int LZ_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] bcd_o,
  output logic       tick_o,
  output logic       wrap_o,
  output logic [3:0] digit_o,
  output logic [1:0] dig_sel_n
);

  logic       step_stb;
  logic       scan_stb;
  logic [7:0] bcd_q, bcd_d;
  logic       tick_q, tick_d;
  logic       wrap_q, wrap_d;
  logic       sel_q, sel_d;
  logic [3:0] digit_q, digit_d;
  logic [1:0] dig_sel_n_q, dig_sel_n_d;

  strobe_div #(.DIV(TICK_DIV)) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (clear | load),
    .stb_o    (step_stb)
  );

  strobe_div #(.DIV(SCAN_DIV)) u_scanner (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .sync_clr (1'b0),
    .stb_o    (scan_stb)
  );

  // clear beats load beats step; both override a coincident step entirely
  always_comb begin
    bcd_d  = bcd_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (clear) begin
      bcd_d = 8'h00;
    end else if (load) begin
      bcd_d = bcd_clamp(load_val);
    end else if (step_stb) begin
      tick_d = 1'b1;
      if (up) begin
        bcd_d  = bcd_inc(bcd_q);
        wrap_d = (bcd_q == 8'h99);
      end else begin
        bcd_d  = bcd_dec(bcd_q);
        wrap_d = (bcd_q == 8'h00);
      end
    end
  end

  // Mux uses the next select so digit and select change on the same edge
  always_comb begin
    sel_d       = sel_q ^ scan_stb;
    dig_sel_n_d = 2'b11;
    digit_d     = bcd_q[3:0];
    if (!sel_d) begin
      dig_sel_n_d[UNITS] = 1'b0;
    end else begin
      dig_sel_n_d[TENS] = 1'b0;
      if ((LZ_BLANK != 0) && (bcd_q[7:4] == 4'd0)) begin
        digit_d = DIGIT_BLANK;
      end else begin
        digit_d = bcd_q[7:4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q       <= 8'h00;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
      sel_q       <= 1'b0;
      digit_q     <= 4'h0;
      dig_sel_n_q <= 2'b10;
    end else begin
      bcd_q       <= bcd_d;
      tick_q      <= tick_d;
      wrap_q      <= wrap_d;
      sel_q       <= sel_d;
      digit_q     <= digit_d;
      dig_sel_n_q <= dig_sel_n_d;
    end
  end

  assign bcd_o     = bcd_q;
  assign tick_o    = tick_q;
  assign wrap_o    = wrap_q;
  assign digit_o   = digit_q;
  assign dig_sel_n = dig_sel_n_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with TICK_DIV=4, SCAN_DIV=3, LZ_BLANK=1.
module tb_bcd_scan_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       clear;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd_o;
  logic       tick_o;
  logic       wrap_o;
  logic [3:0] digit_o;
  logic [1:0] dig_sel_n;

  int checks = 0;
  int errors = 0;
  int cyc;

  bcd_scan_counter #(
    .TICK_DIV (4),
    .SCAN_DIV (3),
    .LZ_BLANK (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .bcd_o     (bcd_o),
    .tick_o    (tick_o),
    .wrap_o    (wrap_o),
    .digit_o   (digit_o),
    .dig_sel_n (dig_sel_n)
  );

  // clock / reset-relative edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic       clear;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic [7:0] bcd;
    logic       tick;
    logic       wrap;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic c, input logic l, input logic [7:0] lv,
                         input logic e, input logic u,
                         input logic [7:0] b, input logic t, input logic w);
    vec_t v;
    v.clear = c; v.load = l; v.lv = lv; v.en = e; v.up = u;
    v.bcd = b; v.tick = t; v.wrap = w;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                       input logic e, input logic u);
    clear = c; load = l; load_val = lv; en = e; up = u;
  endtask

  // expected scanner output from edge count since reset release
  task automatic check_scan(input string tag, input logic [7:0] cnt);
    logic       s;
    logic [3:0] exp_d;
    logic [1:0] exp_s;
    s = ((cyc / 3) % 2) == 1;
    if (s) begin
      exp_s = 2'b01;
      exp_d = (cnt[7:4] == 4'd0) ? 4'hF : cnt[7:4];
    end else begin
      exp_s = 2'b10;
      exp_d = cnt[3:0];
    end
    check($sformatf("%s digit cyc%0d", tag, cyc), {28'd0, digit_o}, {28'd0, exp_d});
    check($sformatf("%s dig_sel_n cyc%0d", tag, cyc), {30'd0, dig_sel_n}, {30'd0, exp_s});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // async reset mid-count with count 42 and tens slot showing
    drive(1'b0, 1'b1, 8'h42, 1'b1, 1'b1);
    tick_clk();
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("load 42", {24'd0, bcd_o}, 32'h42);
    tick_clk();
    tick_clk();
    check("pre-reset digit", {28'd0, digit_o}, 32'h4);
    check("pre-reset dig_sel_n", {30'd0, dig_sel_n}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async rst bcd", {24'd0, bcd_o}, 32'h00);
    check("async rst digit", {28'd0, digit_o}, 32'h0);
    check("async rst dig_sel_n", {30'd0, dig_sel_n}, 32'h2);
    check("async rst tick", {31'd0, tick_o}, 32'h0);
    check("async rst wrap", {31'd0, wrap_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick_clk();
      check($sformatf("post-rst tick e%0d", k), {31'd0, tick_o}, (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("post-rst bcd e%0d", k), {24'd0, bcd_o}, (k == 4) ? 32'h01 : 32'h00);
    end

    // per-cycle table: inputs before the edge, outputs after it
    add_row(0, 1, 8'h98, 1, 1, 8'h98, 0, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 1, 8'h98, 0, 0);
    add_row(0, 0, 8'h00, 1, 1, 8'h99, 1, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 1, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 1, 1, 8'h00, 1, 1);
    add_row(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h99, 1, 1);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h98, 1, 0);
    add_row(0, 1, 8'h3C, 1, 0, 8'h39, 0, 0);
    add_row(0, 1, 8'hFA, 1, 0, 8'h99, 0, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 1, 8'h99, 0, 0);
    add_row(0, 1, 8'h12, 1, 1, 8'h12, 0, 0);
    for (int i = 0; i < 3; i++) add_row(0, 0, 8'h00, 1, 1, 8'h12, 0, 0);
    add_row(1, 1, 8'h55, 1, 1, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 1, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h99, 1, 1);
    add_row(0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h99, 0, 0);
    add_row(0, 0, 8'h00, 1, 0, 8'h98, 1, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].clear, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].up);
      tick_clk();
      check($sformatf("row%0d bcd", i), {24'd0, bcd_o}, {24'd0, tbl[i].bcd});
      check($sformatf("row%0d tick", i), {31'd0, tick_o}, {31'd0, tbl[i].tick});
      check($sformatf("row%0d wrap", i), {31'd0, wrap_o}, {31'd0, tbl[i].wrap});
    end

    // scanner with leading-zero blanking, count frozen
    drive(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
    tick_clk();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick_clk();
    for (int k = 0; k < 12; k++) begin
      check_scan("scan07", 8'h07);
      tick_clk();
    end
    drive(1'b0, 1'b1, 8'h47, 1'b0, 1'b0);
    tick_clk();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick_clk();
    for (int k = 0; k < 12; k++) begin
      check_scan("scan47", 8'h47);
      tick_clk();
    end
    check("count frozen", {24'd0, bcd_o}, 32'h47);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
